// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 absorb/pad sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Contents: controller state enum, Keccak rate per digest size, rate-in-words helper, pad bytes.
package sha3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_PERMUTE,
    ST_SQUEEZE
  } state_e;

  // Keccak rate r = 1600 - 2*digest_bits, indexed by the digest select code.
  localparam int RATE_BITS_224 = 1152;
  localparam int RATE_BITS_256 = 1088;
  localparam int RATE_BITS_384 = 832;
  localparam int RATE_BITS_512 = 576;

  // SHA-3 domain-separation bits (01) plus first pad bit, and the closing pad bit.
  localparam logic [7:0] PAD_DS  = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  // Number of stream words in one rate block for the given digest select.
  function automatic logic [7:0] rate_words(input logic [1:0] sel, input int data_width);
    int r;
    case (sel)
      2'd0:    r = RATE_BITS_224;
      2'd1:    r = RATE_BITS_256;
      2'd2:    r = RATE_BITS_384;
      default: r = RATE_BITS_512;
    endcase
    return 8'(r / data_width);
  endfunction

endpackage

// File: rtl/sha3_pad_merge.sv
// Merges message bytes with SHA-3 padding into one rate word.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: data_i/keep_i message word and byte mask; last_i marks the final message beat
// (0x06 goes in the first unkept byte); pend_i forces 0x06 into byte 0; final_i ORs 0x80
// into the top byte; word_o is the word to XOR into the state.
module sha3_pad_merge
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_BYTES-1:0] keep_i,
  input  logic                  last_i,
  input  logic                  pend_i,
  input  logic                  final_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic prev_kept;

  always_comb begin
    word_o    = '0;
    prev_kept = 1'b1;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (keep_i[k]) begin
        word_o[8*k +: 8] = data_i[8*k +: 8];
      end
      // keep is contiguous from byte 0, so the first unkept byte follows a kept one
      if (last_i && !keep_i[k] && prev_kept) begin
        word_o[8*k +: 8] = word_o[8*k +: 8] | PAD_DS;
      end
      prev_kept = keep_i[k];
    end
    if (pend_i) begin
      word_o[7:0] = word_o[7:0] | PAD_DS;
    end
    if (final_i) begin
      word_o[DATA_WIDTH-1 -: 8] = word_o[DATA_WIDTH-1 -: 8] | PAD_END;
    end
  end

endmodule

// File: rtl/sha3_seq_ctrl.sv
// SHA-3 sequencer: absorbs an AXI-Stream message into rate words, pads, runs permutations, hands off to squeeze.
// Latency: Blk_we one cycle after each accepted beat; Perm_start one cycle after the last word of a block.
// Backpressure: S_TREADY high only in IDLE/ABSORB; low during PAD, PERMUTE, SQUEEZE and reset.
// Ports: ACLK/ARESET; S_T* message stream with S_TUSER digest select and Mode; State_clr, Blk_we/idx/word
// state writes; Perm_start/Perm_done core handshake; Sq_ready/tuser/mode/last serializer; Busy.
module sha3_seq_ctrl
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic [DATA_BYTES-1:0] S_TKEEP,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic                  S_TLAST,
  input  logic [1:0]            S_TUSER,
  input  logic                  Mode,
  output logic                  State_clr,
  output logic                  Blk_we,
  output logic [7:0]            Blk_idx,
  output logic [DATA_WIDTH-1:0] Blk_word,
  output logic                  Perm_start,
  input  logic                  Perm_done,
  output logic                  Sq_ready,
  output logic [1:0]            Sq_tuser,
  output logic                  Sq_mode,
  input  logic                  Sq_last,
  output logic                  Busy
);

  state_e                state_q, state_d;
  logic [7:0]            idx_q, idx_d;
  logic                  final_q, final_d;      // block being permuted is the message's last
  logic                  pend_q, pend_d;        // 0x06 still owed to byte 0 of the next pad word
  logic                  owe_q, owe_d;          // a pad block must follow the current permutation
  logic                  start_pend_q, start_pend_d;
  logic [1:0]            sq_tuser_q, sq_tuser_d;
  logic                  sq_mode_q, sq_mode_d;
  logic                  state_clr_q, state_clr_d;
  logic                  blk_we_q, blk_we_d;
  logic [7:0]            blk_idx_q, blk_idx_d;
  logic [DATA_WIDTH-1:0] blk_word_q, blk_word_d;
  logic                  perm_start_q, perm_start_d;

  logic                  in_rx, beat, in_pad, idx_last, keep_full;
  logic [7:0]            rw;
  logic [DATA_WIDTH-1:0] mg_data, mg_word;
  logic [DATA_BYTES-1:0] mg_keep;
  logic                  mg_last, mg_pend, mg_final;

  assign in_rx     = (state_q == ST_IDLE) || (state_q == ST_ABSORB);
  assign S_TREADY  = in_rx & ~ARESET;
  assign beat      = S_TVALID & S_TREADY;
  assign in_pad    = (state_q == ST_PAD);
  // The first beat's select is not latched yet, so IDLE looks at the live S_TUSER.
  assign rw        = rate_words((state_q == ST_IDLE) ? S_TUSER : sq_tuser_q, DATA_WIDTH);
  assign idx_last  = (idx_q == rw - 8'd1);
  assign keep_full = &S_TKEEP;

  // A full last beat landing on the final rate word leaves no room for padding; it is deferred.
  assign mg_data  = in_pad ? '0 : S_TDATA;
  assign mg_keep  = in_pad ? '0 : S_TKEEP;
  assign mg_last  = ~in_pad & S_TLAST;
  assign mg_pend  = in_pad & pend_q;
  assign mg_final = in_pad ? idx_last : (S_TLAST & idx_last & ~keep_full);

  sha3_pad_merge #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_BYTES(DATA_BYTES)
  ) u_pad_merge (
    .data_i (mg_data),
    .keep_i (mg_keep),
    .last_i (mg_last),
    .pend_i (mg_pend),
    .final_i(mg_final),
    .word_o (mg_word)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    final_d      = final_q;
    pend_d       = pend_q;
    owe_d        = owe_q;
    start_pend_d = 1'b0;
    sq_tuser_d   = sq_tuser_q;
    sq_mode_d    = sq_mode_q;
    state_clr_d  = 1'b0;
    blk_we_d     = 1'b0;
    blk_idx_d    = '0;
    blk_word_d   = '0;
    perm_start_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_ABSORB: begin
        if (beat) begin
          if (state_q == ST_IDLE) begin
            sq_tuser_d  = S_TUSER;
            sq_mode_d   = Mode;
            state_clr_d = 1'b1;
          end
          blk_we_d   = 1'b1;
          blk_idx_d  = idx_q;
          blk_word_d = mg_word;
          if (idx_last) begin
            idx_d        = '0;
            state_d      = ST_PERMUTE;
            start_pend_d = 1'b1;
            if (S_TLAST) begin
              final_d = ~keep_full;
              owe_d   = keep_full;
              pend_d  = keep_full;
            end
          end else begin
            idx_d = idx_q + 8'd1;
            if (S_TLAST) begin
              state_d = ST_PAD;
              pend_d  = keep_full;
            end else begin
              state_d = ST_ABSORB;
            end
          end
        end
      end

      ST_PAD: begin
        blk_we_d   = 1'b1;
        blk_idx_d  = idx_q;
        blk_word_d = mg_word;
        pend_d     = 1'b0;
        if (idx_last) begin
          idx_d        = '0;
          state_d      = ST_PERMUTE;
          start_pend_d = 1'b1;
          final_d      = 1'b1;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      ST_PERMUTE: begin
        // First PERMUTE cycle launches the start pulse; done is only honoured after it.
        if (start_pend_q) begin
          perm_start_d = 1'b1;
        end else if (Perm_done && !perm_start_q) begin
          if (final_q) begin
            state_d = ST_SQUEEZE;
            final_d = 1'b0;
          end else if (owe_q) begin
            state_d = ST_PAD;
            owe_d   = 1'b0;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end

      ST_SQUEEZE: begin
        if (Sq_last) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      final_q      <= 1'b0;
      pend_q       <= 1'b0;
      owe_q        <= 1'b0;
      start_pend_q <= 1'b0;
      sq_tuser_q   <= '0;
      sq_mode_q    <= 1'b0;
      state_clr_q  <= 1'b0;
      blk_we_q     <= 1'b0;
      blk_idx_q    <= '0;
      blk_word_q   <= '0;
      perm_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      final_q      <= final_d;
      pend_q       <= pend_d;
      owe_q        <= owe_d;
      start_pend_q <= start_pend_d;
      sq_tuser_q   <= sq_tuser_d;
      sq_mode_q    <= sq_mode_d;
      state_clr_q  <= state_clr_d;
      blk_we_q     <= blk_we_d;
      blk_idx_q    <= blk_idx_d;
      blk_word_q   <= blk_word_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign State_clr  = state_clr_q;
  assign Blk_we     = blk_we_q;
  assign Blk_idx    = blk_idx_q;
  assign Blk_word   = blk_word_q;
  assign Perm_start = perm_start_q;
  assign Sq_ready   = (state_q == ST_SQUEEZE);
  assign Sq_tuser   = sq_tuser_q;
  assign Sq_mode    = sq_mode_q;
  assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha3_seq_ctrl.sv
// Bench for sha3_seq_ctrl at DATA_WIDTH=16: random and directed messages against a byte-level pad10*1 model.
// Latency: n/a. Backpressure: stream driver holds each beat until S_TREADY.
// Responders model the permutation core and the output serializer with random delays.
module tb_sha3_seq_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [15:0] S_TDATA = '0;
  logic [1:0]  S_TKEEP = '0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic        S_TLAST = 1'b0;
  logic [1:0]  S_TUSER = '0;
  logic        Mode = 1'b0;
  logic        State_clr, Blk_we, Perm_start, Sq_ready, Sq_mode, Busy;
  logic [7:0]  Blk_idx;
  logic [15:0] Blk_word;
  logic [1:0]  Sq_tuser;
  logic        Perm_done = 1'b0;
  logic        Sq_last = 1'b0;

  sha3_seq_ctrl #(.DATA_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .S_TLAST(S_TLAST), .S_TUSER(S_TUSER), .Mode(Mode),
    .State_clr(State_clr), .Blk_we(Blk_we), .Blk_idx(Blk_idx), .Blk_word(Blk_word),
    .Perm_start(Perm_start), .Perm_done(Perm_done),
    .Sq_ready(Sq_ready), .Sq_tuser(Sq_tuser), .Sq_mode(Sq_mode), .Sq_last(Sq_last),
    .Busy(Busy)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int rate_bits [4] = '{1152, 1088, 832, 576};

  // Expectations shared with the monitor (written only by the main sequence).
  int         exp_rw = 68;
  logic [1:0] exp_tuser = 2'd0;
  logic       exp_mode = 1'b0;
  bit         perm_auto = 1'b1;
  int         inject_cnt = 0;

  // Monitor-owned cumulative observations.
  logic [7:0]  mon_idx[$];
  logic [15:0] mon_word[$];
  int perm_cnt = 0, clr_cnt = 0, clr_late = 0, perm_bad = 0;
  int tail_bad = 0, sq_cnt = 0, sq_bad = 0, sq_done = 0;

  initial begin : monitor
    bit         in_tail = 0, clr_seen = 0, prev_we = 0, prev_sq_hs = 0;
    logic [7:0] prev_idx = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        in_tail = 0; clr_seen = 0; prev_we = 0; prev_sq_hs = 0;
      end else begin
        if (prev_sq_hs) begin
          if (Sq_ready || Busy) sq_bad++;
          sq_done++;
          in_tail  = 0;
          clr_seen = 0;
        end
        if (in_tail && S_TREADY) tail_bad++;
        if (S_TVALID && S_TREADY && S_TLAST) in_tail = 1;
        if (State_clr) begin clr_cnt++; clr_seen = 1; end
        if (Blk_we) begin
          if (!clr_seen) clr_late++;
          mon_idx.push_back(Blk_idx);
          mon_word.push_back(Blk_word);
        end
        if (Perm_start) begin
          perm_cnt++;
          if (!(prev_we && int'(prev_idx) == exp_rw - 1)) perm_bad++;
        end
        if (Sq_ready) begin
          sq_cnt++;
          if (Sq_tuser !== exp_tuser || Sq_mode !== exp_mode) sq_bad++;
        end
        prev_we    = Blk_we;
        prev_idx   = Blk_idx;
        prev_sq_hs = Sq_ready && Sq_last;
      end
    end
  end

  // Permutation core: optional stray done in the Perm_start cycle, then a real done later.
  initial begin : perm_resp
    int inject_seen = 0;
    forever begin
      @(posedge ACLK); #1;
      Perm_done = 1'b0;
      if (inject_cnt != inject_seen) begin
        inject_seen = inject_cnt;
        Perm_done = 1'b1;
      end else if (perm_auto && Perm_start) begin
        Perm_done = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 4)) begin
          @(posedge ACLK); #1;
          Perm_done = 1'b0;
        end
        Perm_done = 1'b1;
      end
    end
  end

  initial begin : sq_resp
    forever begin
      @(posedge ACLK); #1;
      if (Sq_last) Sq_last = 1'b0;
      else if (Sq_ready && $urandom_range(0, 2) == 0) Sq_last = 1'b1;
    end
  end

  logic [7:0] msg_q[$];
  int b_wr;

  task automatic fill_rand(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  function automatic logic [15:0] wr_at(input int i);
    if (i < mon_word.size()) return mon_word[i];
    return 16'hxxxx;
  endfunction

  task automatic send_msg(input logic [1:0] tu, input logic md, output bit ok);
    int nb, w;
    logic [15:0] d;
    logic [1:0] k;
    logic rdy;
    ok = 1;
    nb = (msg_q.size() == 0) ? 1 : (msg_q.size() + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 2)) begin
        S_TVALID = 1'b0;
        @(posedge ACLK); #1;
      end
      d = 16'($urandom);
      k = 2'b00;
      for (int j = 0; j < 2; j++) begin
        if (2 * b + j < msg_q.size()) begin
          d[8*j +: 8] = msg_q[2*b+j];
          k[j] = 1'b1;
        end
      end
      S_TVALID = 1'b1; S_TDATA = d; S_TKEEP = k; S_TLAST = (b == nb - 1);
      // Select and mode are only meaningful on the first beat; scramble them afterwards.
      S_TUSER = (b == 0) ? tu : 2'($urandom);
      Mode    = (b == 0) ? md : 1'($urandom);
      w = 0;
      do begin
        @(negedge ACLK); rdy = S_TREADY;
        @(posedge ACLK); #1;
        w++;
      end while (!rdy && w < 3000);
      if (!rdy) begin
        chk("beat_timeout", 0, 1);
        ok = 0;
        break;
      end
    end
    S_TVALID = 1'b0; S_TLAST = 1'b0; S_TKEEP = '0;
  endtask

  task automatic run_msg(input string tag, input logic [1:0] tu, input logic md);
    logic [7:0]  pb[$];
    logic [15:0] ew[$];
    int rb, nblk, total, w;
    int b_perm, b_clr, b_late, b_pbad, b_tail, b_sq, b_sqbad, b_done;
    bit ok;
    // Byte-level SHA-3 padding: message || 0x06 || 0* with 0x80 in the block's last byte.
    rb    = rate_bits[tu] / 8;
    nblk  = msg_q.size() / rb + 1;
    total = nblk * rb;
    pb = msg_q;
    while (pb.size() < total) pb.push_back(8'h00);
    pb[msg_q.size()] = pb[msg_q.size()] | 8'h06;
    pb[total-1]      = pb[total-1] | 8'h80;
    for (int i = 0; i < total / 2; i++) ew.push_back({pb[2*i+1], pb[2*i]});
    exp_rw = rb / 2; exp_tuser = tu; exp_mode = md;
    b_wr = mon_word.size(); b_perm = perm_cnt; b_clr = clr_cnt; b_late = clr_late;
    b_pbad = perm_bad; b_tail = tail_bad; b_sq = sq_cnt; b_sqbad = sq_bad; b_done = sq_done;
    send_msg(tu, md, ok);
    w = 0;
    while (ok && sq_done == b_done && w < 5000) begin
      @(posedge ACLK); #1;
      w++;
    end
    chk({tag, "_sq_done"}, sq_done - b_done, 1);
    chk({tag, "_n_writes"}, mon_word.size() - b_wr, ew.size());
    for (int i = 0; i < ew.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), wr_at(b_wr + i), ew[i]);
      if (b_wr + i < mon_idx.size())
        chk($sformatf("%s_idx%0d", tag, i), mon_idx[b_wr+i], i % exp_rw);
    end
    chk({tag, "_perm_cnt"}, perm_cnt - b_perm, nblk);
    chk({tag, "_clr_cnt"}, clr_cnt - b_clr, 1);
    chk({tag, "_clr_late"}, clr_late - b_late, 0);
    chk({tag, "_perm_timing"}, perm_bad - b_pbad, 0);
    chk({tag, "_tready_tail"}, tail_bad - b_tail, 0);
    chk({tag, "_sq_fields"}, sq_bad - b_sqbad, 0);
    chk({tag, "_sq_seen"}, (sq_cnt > b_sq), 1);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int b_perm, b_sq;
    bit ok;

    #3;
    chk("rst_tready", S_TREADY, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_blk_we", Blk_we, 0);
    chk("rst_clr", State_clr, 0);
    chk("rst_perm_start", Perm_start, 0);
    chk("rst_sq_ready", Sq_ready, 0);
    chk("rst_sq_tuser", Sq_tuser, 0);
    chk("rst_sq_mode", Sq_mode, 0);
    #19 ARESET = 1'b0;
    @(negedge ACLK);
    chk("idle_tready", S_TREADY, 1);
    @(posedge ACLK); #1;

    msg_q.delete();
    run_msg("empty", 2'd1, 1'b0);
    chk("empty_w0", wr_at(b_wr), 16'h0006);
    chk("empty_w67", wr_at(b_wr + 67), 16'h8000);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 2'd1, 1'b0);
    chk("abc_w0", wr_at(b_wr), 16'h6261);
    chk("abc_w1", wr_at(b_wr + 1), 16'h0663);
    chk("abc_w67", wr_at(b_wr + 67), 16'h8000);

    fill_rand(134);
    run_msg("b67", 2'd1, 1'b0);
    chk("b67_w67", wr_at(b_wr + 67), 16'h8006);

    fill_rand(136);
    run_msg("b68", 2'd1, 1'b0);
    chk("b68_pad_w0", wr_at(b_wr + 68), 16'h0006);
    chk("b68_pad_w67", wr_at(b_wr + 135), 16'h8000);

    fill_rand(50);
    run_msg("t3m1", 2'd3, 1'b1);
    chk("t3m1_len", mon_word.size() - b_wr, 36);
    fill_rand(9);
    run_msg("after_t3", 2'd2, 1'b0);

    // Odd length ending one byte short of a block: 0x06 and 0x80 share the last byte.
    for (int t = 0; t < 4; t++) begin
      fill_rand(rate_bits[t] / 8 - 1);
      run_msg($sformatf("rbm1_t%0d", t), 2'(t), 1'(t));
      chk($sformatf("rbm1_t%0d_last", t), wr_at(b_wr + rate_bits[t] / 16 - 1) >> 8, 8'h86);
    end

    // Reset while waiting for the permutation of a full final block.
    perm_auto = 1'b0;
    fill_rand(72);
    exp_rw = 36; exp_tuser = 2'd3; exp_mode = 1'b0;
    b_perm = perm_cnt;
    send_msg(2'd3, 1'b0, ok);
    repeat (4) @(posedge ACLK);
    #2;
    chk("midrst_busy_pre", Busy, 1);
    chk("midrst_perm_pre", perm_cnt - b_perm, 1);
    ARESET = 1'b1;
    #1;
    chk("midrst_busy_async", Busy, 0);
    chk("midrst_tready_async", S_TREADY, 0);
    @(posedge ACLK); #2;
    ARESET = 1'b0;
    b_perm = perm_cnt; b_sq = sq_cnt; b_wr = mon_word.size();
    @(posedge ACLK); #1;
    inject_cnt++;
    repeat (20) @(posedge ACLK);
    #1;
    chk("midrst_no_perm", perm_cnt - b_perm, 0);
    chk("midrst_no_sq", sq_cnt - b_sq, 0);
    chk("midrst_no_we", mon_word.size() - b_wr, 0);
    chk("midrst_busy", Busy, 0);
    perm_auto = 1'b1;
    fill_rand(20);
    run_msg("post_rst", 2'd1, 1'b0);

    for (int m = 0; m < 10; m++) begin
      fill_rand($urandom_range(0, 200));
      run_msg($sformatf("rnd%0d", m), 2'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sha3_seq_ctrl.md
SHA3_SEQ_CTRL -- requirements
Module: sha3_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning stream/block word width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter DATA_BYTES, default DATA_WIDTH/8, meaning bytes per word (derived; not overridden).
REQ-003 SHALL use one clock and an asynchronous active-high reset; ports ACLK and ARESET are listed first below.
REQ-004 ACLK  in  1  sole clock; all registers update on the rising edge.
REQ-005 ARESET  in  1  asynchronous active-high reset.
REQ-006 S_TDATA  in  DATA_WIDTH  message word; byte k occupies bits [8k+7:8k].
REQ-007 S_TKEEP  in  DATA_BYTES  valid-byte mask; all ones except on the last beat, where it is contiguous from byte 0 (all zeros allowed).
REQ-008 S_TVALID / S_TREADY  in / out  1 / 1  AXI-Stream handshake.
REQ-009 S_TLAST  in  1  marks the final beat of a message.
REQ-010 S_TUSER  in  2  digest select: 0=224, 1=256, 2=384, 3=512.
REQ-011 Mode  in  1  squeeze mode forwarded to the output serializer (1=digest only, 0=full state).
REQ-012 State_clr  out  1  one-cycle pulse that zeroes the Keccak state at message start.
REQ-013 Blk_we / Blk_idx / Blk_word  out  1 / 8 / DATA_WIDTH  rate-word write (XOR into the state) at word index Blk_idx.
REQ-014 Perm_start / Perm_done  out / in  1 / 1  permutation start pulse; completion pulse from the core.
REQ-015 Sq_ready / Sq_tuser / Sq_mode / Sq_last  out / out / out / in  1 / 2 / 1 / 1  serializer Ready, TUSER and Mode; serializer Last.
REQ-016 Busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL define the rate in words as RW = R/DATA_WIDTH, with R = 1152, 1088, 832 and 576 bits for TUSER 0 to 3 (DATA_WIDTH=16 gives 72, 68, 52 and 36).
REQ-018 SHALL implement the states IDLE, ABSORB, PAD, PERMUTE and SQUEEZE.
REQ-019 IDLE: S_TREADY=1; the first accepted beat latches S_TUSER into Sq_tuser and Mode into Sq_mode, pulses State_clr, processes that beat as an ABSORB beat and enters ABSORB.
REQ-020 ABSORB: S_TREADY=1; each accepted beat writes Blk_word=S_TDATA at Blk_idx=idx, then increments idx.
REQ-021 Blk_we, Blk_idx and Blk_word SHALL be registered, asserted exactly one cycle after the handshake; State_clr SHALL precede or coincide with the first Blk_we.
REQ-022 Last-beat padding: the first byte not set in S_TKEEP SHALL be ORed with 0x06; if idx=RW-1, byte DATA_BYTES-1 SHALL be ORed with 0x80; both applied to the same byte give 0x86.
REQ-023 If the last beat has S_TKEEP all ones, a pending-0x06 flag SHALL be set, and the first PAD word SHALL carry 0x06 in byte 0.
REQ-024 PAD: S_TREADY=0; emit one write per cycle (zero words, plus pending 0x06 where set) up to idx=RW-1, whose byte DATA_BYTES-1 SHALL be ORed with 0x80; then enter PERMUTE as final.
REQ-025 A write at idx=RW-1 SHALL be followed by Perm_start one cycle after the last Blk_we, with idx reset to 0.
REQ-026 After the final write of a message, transition to PERMUTE with a final flag, or to PAD if padding is still owed, i.e. the last beat filled idx=RW-1 without 0x80.
REQ-027 PERMUTE: S_TREADY=0; wait for Perm_done. On Perm_done, return to ABSORB (not final) or PAD (padding owed) or SQUEEZE (final).
REQ-028 Perm_done SHALL be ignored outside PERMUTE and in the cycle of Perm_start.
REQ-029 SQUEEZE: Sq_ready=1 until Sq_last is sampled high; the next cycle Sq_ready=0 and the state returns to IDLE.
REQ-030 S_TUSER and Mode changes after the first beat SHALL NOT affect the current message.

Reset
REQ-031 ARESET SHALL immediately force the state to IDLE, with idx=0 and all flags cleared.
REQ-032 Output reset values: S_TREADY=0 while ARESET is high, then 1 in IDLE; all other outputs 0, with Sq_tuser=0 and Sq_mode=0.
REQ-033 Reset mid-message SHALL discard the message, and no Perm_start or Sq_ready SHALL follow.

Structure
REQ-034 sha3_pkg SHALL hold the state enum, the rate-bit constants, a rate-words function, and the pad constants 0x06 and 0x80.
REQ-035 The padding byte-merge logic (data, keep, pending flag and final-word flag to Blk_word) SHALL be a combinational sub-module sha3_pad_merge.

Verification (DATA_WIDTH=16, TUSER=1 unless stated, RW=68)
REQ-036 Empty message (TKEEP=00, TLAST): 68 writes, with word 0 = 0x0006 and word 67 = 0x8000; one Perm_start; then SQUEEZE.
REQ-037 "abc" sent as beats 0x6261 (TKEEP=11) and 0x0063 (TKEEP=01, TLAST): word 0 = 0x6261, word 1 = 0x0663, words 2-66 = 0, word 67 = 0x8000.
REQ-038 67 full beats, the last with TLAST: word 67 = 0x8006; exactly one permutation.
REQ-039 68 full beats, the last with TLAST: Perm_start, then a PAD block with word 0 = 0x0006 and word 67 = 0x8000, then a second Perm_start; S_TREADY=0 throughout.
REQ-040 TUSER=3, Mode=1: block length 36 words, Sq_tuser=3 and Sq_mode=1; Sq_ready drops one cycle after Sq_last and the next message is accepted in IDLE.
REQ-041 ARESET pulse during PERMUTE, then Perm_done arriving: no SQUEEZE, Busy=0, and the next message starts with State_clr.
